// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer around the branch predictor: picks the next fetch address, drives flushes, gates the predictor.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_redirect_ctrl #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump_pred,
  input  logic [15:0] jump_pred_adr,
  input  logic        jump_pred_miss,
  input  logic        jump_pred_adr_miss,
  input  logic [15:0] ALUres_mem,
  input  logic [15:0] pcinc_evac,
  output logic [15:0] pc,
  output logic        pc_valid,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        pred_enable,
  output logic [1:0]  state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] pred_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int unsigned PC_W  = 16;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pc_valid_q;
  logic             recover;
  logic             pred_take;

  // State, PC and drain counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= INIT;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      pc_valid_q <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      pc_q       <= pc_nxt;
      cnt_q      <= cnt_nxt;
      pc_valid_q <= (nxt_state == RUN) || (nxt_state == DRAIN);
    end
  end

  // Next-state, next-PC priority and combinational flush/enable outputs
  always_comb begin
    nxt_state   = cur_state;
    pc_nxt      = pc_q;
    cnt_nxt     = cnt_q;
    recover     = 1'b0;
    pred_take   = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    pred_enable = 1'b0;

    case (cur_state)
      RUN, DRAIN: begin
        recover     = jump_pred_adr_miss | jump_pred_miss;
        pred_take   = (cur_state == RUN) && jump_pred && !stall && !recover;
        pred_enable = (cur_state == RUN);

        if (jump_pred_adr_miss)  pc_nxt = ALUres_mem;
        else if (jump_pred_miss) pc_nxt = pcinc_evac;
        else if (pred_take)      pc_nxt = jump_pred_adr;
        else if (!stall)         pc_nxt = PC_W'(pc_q + 16'd1);

        // Recovery (re)loads the drain window; it only counts down on free-running cycles
        if (recover) begin
          nxt_state = DRAIN;
          cnt_nxt   = CNT_W'(DRAIN_CYCLES);
        end else if ((cur_state == DRAIN) && !stall) begin
          cnt_nxt = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            nxt_state = RUN;
            cnt_nxt   = '0;
          end
        end

        flush_if = recover | pred_take;
        flush_id = recover;
        flush_ex = recover;
      end
      default: begin
        nxt_state = RUN;
      end
    endcase

    if (reset) begin
      flush_if    = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      pred_enable = 1'b0;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign state    = cur_state;

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (pred_take && (pred_cnt != 16'hFFFF)) pred_cnt <= pred_cnt + 16'd1;
      if (recover && (miss_cnt != 16'hFFFF))   miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequences the fetch PC around the branch predictor. Each cycle it selects the next fetch address from four sources: sequential increment, predicted target (ID stage), predictor recovery (MEM stage) or hold on a hazard stall. It also drives the pipeline flush lines and keeps the predictor disabled while the wrong-path instructions drain. Sits between the predictor and the IF-stage PC register, and owns that register.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch address after reset
- DRAIN_CYCLES, 2, cycles the predictor is held off after a MEM-stage recovery (legal 1..7)

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard stall; hold PC
- jump_pred  in  1  predictor says "taken" for the instruction in ID
- jump_pred_adr  in  16  predicted target
- jump_pred_miss  in  1  predicted taken, resolved not-taken (MEM)
- jump_pred_adr_miss  in  1  taken with wrong or no predicted target (MEM)
- ALUres_mem  in  16  resolved jump target (MEM)
- pcinc_evac  in  16  fall-through address saved for the last prediction
- pc  out  16  current fetch address (registered)
- pc_valid  out  1  fetch address is meaningful
- flush_if, flush_id, flush_ex  out  1 each  squash the named stage register this cycle
- pred_enable  out  1  predictor may issue predictions
- state  out  2  FSM state, for debug

## Operation
- FSM states: INIT=2'b00, RUN=2'b01, DRAIN=2'b10. 2'b11 is unreachable and decodes as INIT.
- INIT:
  - Entered on reset.
  - pc=RESET_PC, pc_valid=0, pred_enable=0, all flushes 0.
  - Goes to RUN unconditionally after one cycle, with pc unchanged.
- RUN and DRAIN use this next-PC priority, highest first:
  1. jump_pred_adr_miss: next pc=ALUres_mem.
  2. jump_pred_miss: next pc=pcinc_evac.
  3. RUN only, jump_pred && !stall: next pc=jump_pred_adr.
  4. stall: pc held.
  5. Otherwise next pc=pc+1, modulo 2^16 (0xFFFF wraps to 0x0000).
- Recovery (priority 1 or 2):
  - flush_if=flush_id=flush_ex=1 combinationally in the same cycle.
  - Recovery overrides stall.
  - Next state is DRAIN, with the drain counter loaded to DRAIN_CYCLES.
  - A recovery while already in DRAIN reloads the counter.
- Prediction (priority 3): flush_if=1 only. State stays RUN.
- DRAIN:
  - pred_enable=0 and jump_pred is ignored.
  - The 3-bit counter decrements on every cycle that has no stall and no recovery.
  - Counter at 1 and decrementing → next state RUN.
- pred_enable=1 only in RUN. pc_valid=1 in RUN and DRAIN.
- If both miss inputs are high in the same cycle (illegal from the predictor), adr_miss wins. No assertion is required.
- Reset mid-operation: the next posedge forces INIT, pc=RESET_PC and counter=0. Any pending recovery is discarded.

## Timing
- Reset values: pc=RESET_PC, pc_valid=0, pred_enable=0, flush_*=0, state=INIT.
- Redirect latency is one cycle. The event is sampled at posedge N, the new pc is visible after posedge N and is fetched in cycle N+1.
- flush_* and pred_enable are combinational from the current state and inputs. They have no registered delay.
- jump_pred is honored only when stall=0. The predictor re-asserts it while ID is held, so no prediction is buffered.
- Minimum DRAIN length is DRAIN_CYCLES non-stalled cycles.

## Configuration
- FETCH_PERF_CNT_EN:
  - Defined: adds outputs pred_cnt[15:0] and miss_cnt[15:0].
    - pred_cnt increments on each honored prediction.
    - miss_cnt increments on each recovery.
    - Both saturate at 0xFFFF and reset to 0.
  - Undefined: the ports and the counters are absent, and all other behaviour is identical.

## Test plan
- Reset:
  - Hold reset 2 cycles, then release.
  - Expect pc=0x0000, pc_valid=0 for one cycle, then pc_valid=1, pred_enable=1, and pc 0x0001, 0x0002… one per cycle.
- Prediction:
  - At pc=0x0010, pulse jump_pred with jump_pred_adr=0x0040.
  - Expect flush_if=1 in that cycle only, flush_id=flush_ex=0, next pc=0x0040, state stays RUN.
- Address-miss recovery (DRAIN_CYCLES=2):
  - Assert jump_pred_adr_miss with ALUres_mem=0x0080.
  - Expect all three flushes=1 that cycle and next pc=0x0080.
  - Expect DRAIN for 2 cycles with pred_enable=0; a jump_pred pulse inside DRAIN is ignored (pc 0x0081).
  - Expect RUN on the third cycle.
- Taken-miss recovery under stall:
  - With stall=1, assert jump_pred_miss with pcinc_evac=0x0013.
  - Expect all flushes=1 and next pc=0x0013 despite the stall.
  - Then hold stall=1 for 3 cycles: pc stays 0x0013 and DRAIN does not count down.
- Wrap and reset:
  - Run pc through 0xFFFF; expect next pc 0x0000.
  - Assert reset while in DRAIN; expect state INIT and pc=RESET_PC on the next cycle.
- With FETCH_PERF_CNT_EN defined:
  - Run 3 predictions and 2 recoveries; expect pred_cnt=3 and miss_cnt=2.
  - Preload miss_cnt to 0xFFFF via force; expect it to stay at 0xFFFF.
